// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: arbitration
// mode encodings and the wrap-around index helper used by the arbiter.
package stream_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Channel index reached by stepping 'offset' places above 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index first) or
// round-robin starting one place above the previous grant.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  input  logic                      mode,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic             found;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path through the loop can leave one unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (mode == ARB_RR) ? IDX_W'(rr_index(int'(last_grant), k + 1, NUM_CH))
                              : IDX_W'(k);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with a single registered output beat.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant per packet.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int ARB_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]         in_last,
  output logic                      out_last,
`endif
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_sel,
  input  logic                      out_ready
);

  localparam int        IDX_W = $clog2(NUM_CH);
  localparam arb_mode_e MODE  = (ARB_MODE == int'(ARB_RR)) ? ARB_RR : ARB_FIXED;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] arb_req;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  last_grant;
  logic              accept;
  logic              in_fire;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_active;
  logic [IDX_W-1:0] lock_ch;

  // Mid-packet only the locked channel may compete; others wait even if valid.
  assign arb_req = lock_active ? (in_valid & (NUM_CH'(1) << lock_ch)) : in_valid;
`else
  assign arb_req = in_valid;
`endif

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req       (arb_req),
    .last_grant(last_grant),
    .mode      (MODE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The output slot is free when empty or being drained this cycle.
  assign accept   = !out_valid || out_ready;
  assign in_ready = rst_n ? (grant & {NUM_CH{accept}}) : '0;
  assign in_fire  = |in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel     <= '0;
      last_grant  <= IDX_W'(NUM_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last    <= 1'b0;
      lock_active <= 1'b0;
      lock_ch     <= '0;
`endif
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_data    <= ch_data[grant_idx];
      out_sel     <= grant_idx;
      last_grant  <= grant_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last    <= in_last[grant_idx];
      lock_active <= !in_last[grant_idx];
      lock_ch     <= grant_idx;
`endif
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, data width per channel.
REQ-003 SHALL have parameter ARB_MODE, default 1, arbitration mode (0 = fixed priority with lowest index first, 1 = round-robin).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, NUM_CH, per-channel valid.
REQ-007 SHALL have port in_data, input, NUM_CH*DATA_W, packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_ready, output, NUM_CH, per-channel ready.
REQ-009 SHALL have port out_valid, output, 1, registered output valid.
REQ-010 SHALL have port out_data, output, DATA_W, registered output data.
REQ-011 SHALL have port out_sel, output, $clog2(NUM_CH), index of the channel that produced out_data.
REQ-012 SHALL have port out_ready, input, 1, downstream ready.

Function
REQ-013 SHALL complete a transfer on any interface when valid and ready are both high at a rising clk edge.
REQ-014 SHALL hold a single-entry output register; accept = !out_valid || out_ready.
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[g] = accept && in_valid[g], where g is the grant.
REQ-016 SHALL keep in_ready combinational from in_valid, out_valid and out_ready, and SHALL NOT derive it from in_data.
REQ-017 SHALL, in ARB_MODE 0, grant the lowest-index valid channel.
REQ-018 SHALL, in ARB_MODE 1, grant the first valid channel searching upward from last_grant+1 modulo NUM_CH.
REQ-019 SHALL update last_grant only on a completed input transfer.
REQ-020 SHALL load out_data, out_sel and out_valid=1 on the edge that completes an input transfer; latency is exactly 1 cycle from input transfer to out_valid.
REQ-021 SHALL clear out_valid when out_ready=1, out_valid=1 and no input is valid.
REQ-022 SHALL hold out_data and out_sel stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held high; output drain and refill in the same cycle is required.
REQ-024 SHALL drive all in_ready low when in_valid is all zero, and SHALL leave last_grant unchanged.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0 and last_grant=NUM_CH-1, so channel 0 is granted first.
REQ-026 SHALL discard a held output beat when reset asserts mid-operation; no beat is replayed after reset release.
REQ-027 SHALL drive in_ready all zero during reset.

Configuration
REQ-028 SHALL support macro STREAM_MUX_PKT_LOCK_EN.
REQ-029 SHALL, with STREAM_MUX_PKT_LOCK_EN defined, add input in_last (NUM_CH) and output out_last (1), where out_last is registered with out_data.
REQ-030 SHALL, with STREAM_MUX_PKT_LOCK_EN defined, hold the grant on the current channel until its beat with in_last=1 transfers; other channels wait even if valid.
REQ-031 SHALL, without STREAM_MUX_PKT_LOCK_EN, omit in_last and out_last and arbitrate on every beat.
REQ-032 SHALL, with STREAM_MUX_PKT_LOCK_EN defined, reset out_last to 0 and clear the lock.

Structure
REQ-033 SHALL place the ARB_MODE encodings (ARB_FIXED=0, ARB_RR=1) in shared package stream_mux_pkg.
REQ-034 SHALL implement the grant logic in a sub-module rr_arbiter (req, last_grant, mode -> one-hot grant plus index).

Verification
REQ-035 Bench SHALL cover: NUM_CH=4, ARB_MODE=1, all valid, out_ready=1, with data 0xA0..0xA3 -> out_sel sequence 0,1,2,3,0 with one beat per cycle.
REQ-036 Bench SHALL cover: ARB_MODE=0, channels 1 and 3 valid -> only channel 1 is granted while it stays valid.
REQ-037 Bench SHALL cover: out_valid=1 with out_data=0x5C and out_ready=0 for 3 cycles -> out_data=0x5C stable, in_ready=0, then the beat transfers on the first out_ready=1.
REQ-038 Bench SHALL cover: rst_n pulled low while out_valid=1 -> out_valid=0 immediately, and after release channel 0 is granted first.
REQ-039 Bench SHALL cover: with STREAM_MUX_PKT_LOCK_EN, a 3-beat packet on channel 2 while channel 0 is valid -> 3 beats with out_sel=2, out_last only on beat 3, then out_sel=0.
REQ-040 Bench SHALL cover: in_valid=0 for 2 cycles after one beat with out_ready=1 -> out_valid falls 1 cycle after the last beat and last_grant is unchanged.
